mem_arbiter: RTL

Shares the single main-memory port between the instruction-cache and data-cache miss engines of the 3-stage RISC-V core. It accepts one line-sized transaction at a time from either cache, issues it to memory, and sequences the multi-beat write-data or read-response transfer. It returns to idle when the last beat completes. The arbiter sits between the caches and the memory model/DRAM interface, and is the only block that drives the memory request channel.

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side request/response channels and the memory port.
// Combinational only; the bundle carries wires, it adds no latency.
// Handshakes are valid/ready; read responses have no back-pressure.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_resp_valid;
  logic [DATA_W-1:0] ic_resp_data;
  logic              dc_req_valid;
  logic              dc_req_ready;
  logic              dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_wdata_valid;
  logic              dc_wdata_ready;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] dc_resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_wdata_valid;
  logic              mem_wdata_ready;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              busy;

  // Arbiter side: serves the caches and drives the memory request channel.
  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_data,
    input  dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
    output dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata,
    input  mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
    output busy
  );

  // Environment side: the two cache miss engines plus the memory model.
  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_data,
    output dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
    input  dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata,
    output mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache and dcache line transactions (macro ARB_ROUND_ROBIN_EN selects round-robin ties).
// Grant in IDLE cycle T, mem request from T+1, IDLE again the cycle after the last beat (BEATS+2 cycles minimum).
// Memory stalls via mem_req_ready/mem_wdata_ready; dcache write data stalls via dc_wdata_valid; responses cannot stall.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int BEATS  = 4
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              owner;      // 0 = icache, 1 = dcache
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic              grant_ic, grant_dc;
  logic              wr_hs;
  logic              tie_dc;     // who wins when both caches request

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;              // 0 = icache, 1 = dcache

  // Remember the most recent winner so ties alternate.
  always_ff @(posedge clk) begin
    if (reset)                      last_grant <= 1'b0;
    else if (grant_ic || grant_dc)  last_grant <= grant_dc;
  end

  assign tie_dc = ~last_grant;
`else
  assign tie_dc = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant selection, next state and per-state handshake steering.
  always_comb begin
    state_nxt              = state;
    grant_ic               = 1'b0;
    grant_dc               = 1'b0;
    wr_hs                  = 1'b0;
    bus.mem_req_valid      = 1'b0;
    bus.mem_wdata_valid    = 1'b0;
    bus.dc_wdata_ready     = 1'b0;
    bus.ic_resp_valid      = 1'b0;
    bus.dc_resp_valid      = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          grant_dc = bus.dc_req_valid && (!bus.ic_req_valid || tie_dc);
          grant_ic = bus.ic_req_valid && !grant_dc;
          if (grant_ic || grant_dc) state_nxt = REQ;
        end
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_nxt = rw_q ? WDATA : RDATA;
      end
      WDATA: begin
        bus.mem_wdata_valid = bus.dc_wdata_valid;
        bus.dc_wdata_ready  = bus.mem_wdata_ready;
        wr_hs               = bus.dc_wdata_valid && bus.mem_wdata_ready;
        if (wr_hs && (cnt == LAST_BEAT)) state_nxt = IDLE;
      end
      RDATA: begin
        bus.ic_resp_valid = bus.mem_resp_valid && !owner;
        bus.dc_resp_valid = bus.mem_resp_valid && owner;
        if (bus.mem_resp_valid && (cnt == LAST_BEAT)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted transaction and count data beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner  <= 1'b0;
      rw_q   <= 1'b0;
      addr_q <= '0;
      cnt    <= '0;
    end else begin
      if (grant_ic || grant_dc) begin
        owner  <= grant_dc;
        addr_q <= grant_dc ? bus.dc_req_addr : bus.ic_req_addr;
        rw_q   <= grant_dc && bus.dc_req_rw;   // icache only ever reads
      end
      if (state == REQ)
        cnt <= '0;
      else if (wr_hs || (state == RDATA && bus.mem_resp_valid))
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.ic_req_ready = grant_ic;
  assign bus.dc_req_ready = grant_dc;
  assign bus.mem_req_addr = addr_q;
  assign bus.mem_req_rw   = rw_q;
  assign bus.mem_wdata    = bus.dc_wdata;
  assign bus.ic_resp_data = bus.mem_resp_data;
  assign bus.dc_resp_data = bus.mem_resp_data;
  assign bus.busy         = (state != IDLE);
endmodule
